intersection_sequencer: RTL

- Phase controller directly upstream of the left-turn light.
- Arbitrates through traffic, pedestrian walk and the protected/permissive left-turn phase.
- Drives the left-turn light's start/flash inputs and consumes its 2-bit colour output to detect the end of the left phase.
- Directly drives the through-lane light and the pedestrian WALK lamp, and latches a sticky fault if the left light stalls.

---
 rtl/traffic_pkg.sv | 39 +++
 rtl/phase_timer.sv | 40 ++++
 rtl/intersection_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Types shared by the intersection sequencer and the left-turn light it drives.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN        = 2'b00,
    YELLOW       = 2'b01,
    RED          = 2'b10,
    FLASH_YELLOW = 2'b11
  } color_t;

  typedef enum logic [2:0] {
    ALL_RED     = 3'd0,
    THRU_GREEN  = 3'd1,
    THRU_YELLOW = 3'd2,
    PED_WALK    = 3'd3,
    LEFT        = 3'd4,
    FAULT       = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    SRV_THRU = 2'd0,
    SRV_PED  = 2'd1,
    SRV_LEFT = 2'd2
  } served_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic color_t thru_color_of(input phase_t p);
    case (p)
      THRU_GREEN:  return GREEN;
      THRU_YELLOW: return YELLOW;
      FAULT:       return FLASH_YELLOW;
      default:     return RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter holding the dwell remaining in the current phase.
module phase_timer #(
  parameter int unsigned    W         = 8,
  parameter logic [W-1:0]   RESET_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/intersection_sequencer.sv
// Phase controller arbitrating through traffic, pedestrian walk and the left-turn
// phase; drives the left-turn light and watches its colour to end the left phase.
module intersection_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned ALL_RED_TIME     = 2,
  parameter int unsigned THRU_MIN_TIME    = 8,
  parameter int unsigned THRU_MAX_TIME    = 20,
  parameter int unsigned THRU_YELLOW_TIME = 3,
  parameter int unsigned WALK_TIME        = 6,
  parameter int unsigned LEFT_TIMEOUT     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_sensor,
  input  logic       ped_req,
  input  logic       night_mode,
  input  logic [1:0] left_color,
  output logic       left_start,
  output logic       left_flash,
  output logic [1:0] thru_color,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic       fault,
  output logic [2:0] phase
);

  localparam int unsigned CW = $clog2(max_u(max_u(THRU_MAX_TIME, LEFT_TIMEOUT),
                                  max_u(max_u(ALL_RED_TIME, THRU_YELLOW_TIME), WALK_TIME)) + 1);
  localparam logic [CW-1:0] AR_LD  = CW'(ALL_RED_TIME - 1);
  localparam logic [CW-1:0] TG_LD  = CW'(THRU_MAX_TIME - 1);
  localparam logic [CW-1:0] TY_LD  = CW'(THRU_YELLOW_TIME - 1);
  localparam logic [CW-1:0] PW_LD  = CW'(WALK_TIME - 1);
  localparam logic [CW-1:0] MIN_M1 = CW'(THRU_MIN_TIME - 1);
  localparam logic [CW-1:0] LT_M1  = CW'(LEFT_TIMEOUT - 1);

  phase_t        state_q, state_d;
  served_t       served_q, served_d;
  logic          ped_pend_q, ped_pend_d, left_pend_q, left_pend_d;
  logic          seen_nonred_q, seen_nonred_d, left_flash_q, left_flash_d;
  logic          ped_walk_q, left_start_q, ped_ack_q, fault_q;
  logic [1:0]    thru_color_q;
  logic [CW-1:0] elapsed_q, elapsed_d, dwell_ld_s;
  logic          dwell_zero_s, entering_s;

  phase_timer #(.W(CW), .RESET_VAL(AR_LD)) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .load_i     (entering_s),
    .load_val_i (dwell_ld_s),
    .dec_i      (1'b1),
    .zero_o     (dwell_zero_s)
  );

  // Next phase selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALL_RED: begin
        if (!dwell_zero_s) begin
          state_d = ALL_RED;
        end else if (served_q == SRV_THRU && ped_pend_q) begin
          state_d = PED_WALK;
        end else if (served_q != SRV_LEFT && left_pend_q) begin
          state_d = LEFT;
        end else begin
          state_d = THRU_GREEN;
        end
      end
      THRU_GREEN: begin
        if (dwell_zero_s || ((elapsed_q >= MIN_M1) && (ped_pend_q || left_pend_q))) begin
          state_d = THRU_YELLOW;
        end else begin
          state_d = THRU_GREEN;
        end
      end
      THRU_YELLOW, PED_WALK: begin
        if (dwell_zero_s) begin
          state_d = ALL_RED;
        end else begin
          state_d = state_q;
        end
      end
      // A completed cycle on the left light beats the timeout in the same cycle.
      LEFT: begin
        if (seen_nonred_q && (left_color == RED)) begin
          state_d = ALL_RED;
        end else if (elapsed_q == LT_M1) begin
          state_d = FAULT;
        end else begin
          state_d = LEFT;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = ALL_RED;
    endcase
  end

  // Entry-time bookkeeping: dwell reload, demand latches, left-phase flags.
  always_comb begin
    entering_s = (state_d != state_q);
    case (state_d)
      ALL_RED:     dwell_ld_s = AR_LD;
      THRU_GREEN:  dwell_ld_s = TG_LD;
      THRU_YELLOW: dwell_ld_s = TY_LD;
      PED_WALK:    dwell_ld_s = PW_LD;
      default:     dwell_ld_s = {CW{1'b0}};
    endcase
    served_d = served_q;
    if (entering_s) begin
      case (state_d)
        THRU_GREEN: served_d = SRV_THRU;
        PED_WALK:   served_d = SRV_PED;
        LEFT:       served_d = SRV_LEFT;
        default:    served_d = served_q;
      endcase
    end else begin
      served_d = served_q;
    end
    if (entering_s && state_d == PED_WALK) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && state_q != PED_WALK && state_q != FAULT) begin
      ped_pend_d = 1'b1;
    end else begin
      ped_pend_d = ped_pend_q;
    end
    if (entering_s && state_d == LEFT) begin
      left_pend_d = 1'b0;
    end else if (left_sensor) begin
      left_pend_d = 1'b1;
    end else begin
      left_pend_d = left_pend_q;
    end
    if (entering_s && state_d == LEFT) begin
      seen_nonred_d = 1'b0;
      left_flash_d  = night_mode;
    end else if (state_d == LEFT) begin
      seen_nonred_d = seen_nonred_q | (left_color != RED);
      left_flash_d  = left_flash_q;
    end else begin
      seen_nonred_d = 1'b0;
      left_flash_d  = 1'b0;
    end
    if (entering_s) begin
      elapsed_d = {CW{1'b0}};
    end else if (elapsed_q != {CW{1'b1}}) begin
      elapsed_d = elapsed_q + CW'(1);
    end else begin
      elapsed_d = elapsed_q;
    end
  end

  // State and registered Moore outputs decoded from the next phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ALL_RED;
      served_q      <= SRV_THRU;
      ped_pend_q    <= 1'b0;
      left_pend_q   <= 1'b0;
      seen_nonred_q <= 1'b0;
      left_flash_q  <= 1'b0;
      elapsed_q     <= {CW{1'b0}};
      thru_color_q  <= RED;
      ped_walk_q    <= 1'b0;
      left_start_q  <= 1'b0;
      ped_ack_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      served_q      <= served_d;
      ped_pend_q    <= ped_pend_d;
      left_pend_q   <= left_pend_d;
      seen_nonred_q <= seen_nonred_d;
      left_flash_q  <= left_flash_d;
      elapsed_q     <= elapsed_d;
      thru_color_q  <= thru_color_of(state_d);
      ped_walk_q    <= (state_d == PED_WALK);
      left_start_q  <= (state_d == LEFT);
      ped_ack_q     <= entering_s && (state_d == PED_WALK);
      fault_q       <= fault_q | (state_d == FAULT);
    end
  end

  assign phase      = state_q;
  assign thru_color = thru_color_q;
  assign ped_walk   = ped_walk_q;
  assign left_start = left_start_q;
  assign left_flash = left_flash_q;
  assign ped_ack    = ped_ack_q;
  assign fault      = fault_q;

endmodule
